// File: rtl/tone_generation_fsm.sv
// tone_generation_fsm: accepts 3-bit tone ids over valid/ready and
// emits strobed 16-bit sine bursts, each followed by a silent gap.
module tone_generation_fsm #(
  parameter int SAMPLES_PER_SYMBOL = 512,
  parameter int GAP_SAMPLES        = 64,
  parameter int BASE_INC           = 1024
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [2:0]         tone_in,
  input  logic               tone_valid_in,
  output logic               tone_ready_out,
  input  logic               audio_valid_in,
  output logic signed [15:0] audio_out,
  output logic               audio_valid_out,
  output logic               busy_out
);

  localparam int CMAX =
    (SAMPLES_PER_SYMBOL > GAP_SAMPLES) ?
    SAMPLES_PER_SYMBOL : GAP_SAMPLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SYM_LAST =
    CW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        phase_q, phase_d;
  logic [15:0]        inc_q, inc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [15:0] audio_d;
  logic               avalid_d;

  // First quadrant of round(32767*sin(2*pi*n/64)), n = 0..16.
  function automatic logic [15:0] quarter(
    input logic [4:0] i
  );
    case (i)
      5'd0:    return 16'd0;
      5'd1:    return 16'd3212;
      5'd2:    return 16'd6393;
      5'd3:    return 16'd9512;
      5'd4:    return 16'd12539;
      5'd5:    return 16'd15446;
      5'd6:    return 16'd18204;
      5'd7:    return 16'd20787;
      5'd8:    return 16'd23170;
      5'd9:    return 16'd25329;
      5'd10:   return 16'd27245;
      5'd11:   return 16'd28898;
      5'd12:   return 16'd30273;
      5'd13:   return 16'd31356;
      5'd14:   return 16'd32137;
      5'd15:   return 16'd32609;
      5'd16:   return 16'd32767;
      default: return 16'd0;
    endcase
  endfunction

  // Mirror in odd quadrants, negate in the second half-cycle.
  function automatic logic signed [15:0] sine(
    input logic [5:0] idx
  );
    logic [4:0]  off;
    logic [15:0] mag;
    off = idx[4] ?
      5'(5'd16 - {1'b0, idx[3:0]}) :
      {1'b0, idx[3:0]};
    mag = quarter(off);
    return idx[5] ? -$signed(mag) : $signed(mag);
  endfunction

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    inc_d    = inc_q;
    audio_d  = audio_out;
    avalid_d = audio_valid_in;
    unique case (state_q)
      IDLE: begin
        if (audio_valid_in)
          audio_d = '0;
        if (tone_valid_in) begin
          state_d = TONE;
          phase_d = '0;
          cnt_d   = '0;
          inc_d   = 16'((16'(tone_in) + 16'd1) *
                        16'(BASE_INC));
        end
      end
      TONE: begin
        if (audio_valid_in) begin
          audio_d = sine(phase_q[15:10]);
          phase_d = phase_q + inc_q;
          if (cnt_q == SYM_LAST) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GAP: begin
        if (audio_valid_in) begin
          audio_d = '0;
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      phase_q         <= '0;
      inc_q           <= '0;
      cnt_q           <= '0;
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      inc_q           <= inc_d;
      cnt_q           <= cnt_d;
      audio_out       <= audio_d;
      audio_valid_out <= avalid_d;
    end
  end

  assign tone_ready_out = (state_q == IDLE);
  assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_tone_generation_fsm.sv
// tb_tone_generation_fsm: directed checks of burst content, gap
// length, handshake, accept-cycle strobe and mid-burst reset.
module tb_tone_generation_fsm;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic [2:0]         tone_in;
  logic               tone_valid_in;
  logic               tone_ready_out;
  logic               audio_valid_in;
  logic signed [15:0] audio_out;
  logic               audio_valid_out;
  logic               busy_out;

  int n_assert = 0;
  int n_fail   = 0;

  int t0_first [4] = '{0, 3212, 6393, 9512};
  int t3_first [5] = '{0, 12539, 23170, 30273, 32767};
  int t7_pat   [8] = '{0, 23170, 32767, 23170,
                       0, -23170, -32767, -23170};

  always #5 clk_in = ~clk_in;

  tone_generation_fsm dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .tone_in         (tone_in),
    .tone_valid_in   (tone_valid_in),
    .tone_ready_out  (tone_ready_out),
    .audio_valid_in  (audio_valid_in),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .busy_out        (busy_out)
  );

  task automatic check(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic int ref_sine(input int idx);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979 * idx / 64.0);
    if (v >= 0.0)
      return $rtoi(v + 0.5);
    else
      return -$rtoi(-v + 0.5);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobe();
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
  endtask

  initial begin
    logic [15:0] ph;
    int          exp_s;
    int          pulses;

    rst_in         = 1'b1;
    tone_in        = 3'd0;
    tone_valid_in  = 1'b0;
    audio_valid_in = 1'b0;
    tick();
    tick();
    check("rst_audio",  audio_out,       0);
    check("rst_avalid", audio_valid_out, 0);
    check("rst_busy",   busy_out,        0);
    rst_in = 1'b0;
    tick();
    check("rst_ready", tone_ready_out, 1);

    // tone 0, one strobe every 7 clocks
    tone_in       = 3'd0;
    tone_valid_in = 1'b1;
    tick();
    tone_valid_in = 1'b0;
    check("t0_acc_ready", tone_ready_out, 0);
    check("t0_acc_busy",  busy_out,       1);
    ph = '0;
    for (int n = 0; n < 512; n++) begin
      strobe();
      exp_s = ref_sine(int'(ph[15:10]));
      check("t0_valid",  audio_valid_out, 1);
      check("t0_sample", audio_out,       exp_s);
      if (n < 4)
        check("t0_first", audio_out, t0_first[n]);
      ph = ph + 16'd1024;
      if (n == 100) begin
        tone_in       = 3'd3;
        tone_valid_in = 1'b1;
      end
      repeat (6) tick();
      check("t0_pulse", audio_valid_out, 0);
      check("t0_hold",  audio_out,       exp_s);
      if (n >= 100)
        check("busy_ready", tone_ready_out, 0);
    end
    check("t0_gap_busy", busy_out, 1);
    for (int n = 0; n < 64; n++) begin
      check("t0_gap_ready", tone_ready_out, 0);
      strobe();
      check("t0_gap_valid", audio_valid_out, 1);
      check("t0_gap_zero",  audio_out,       0);
      if (n < 63)
        repeat (6) tick();
    end
    check("t0_end_ready", tone_ready_out, 1);
    check("t0_end_busy",  busy_out,       0);

    // held tone 3 is accepted on the next clock
    tick();
    tone_valid_in = 1'b0;
    check("t3_acc_ready", tone_ready_out, 0);
    check("t3_acc_busy",  busy_out,       1);

    // tone 3 with a strobe on every clock
    ph             = '0;
    pulses         = 0;
    audio_valid_in = 1'b1;
    for (int n = 0; n < 576; n++) begin
      tick();
      if (n == 575)
        audio_valid_in = 1'b0;
      if (audio_valid_out)
        pulses++;
      exp_s = (n < 512) ? ref_sine(int'(ph[15:10])) : 0;
      check("b2b_valid",  audio_valid_out, 1);
      check("b2b_sample", audio_out,       exp_s);
      if (n < 5)
        check("t3_first", audio_out, t3_first[n]);
      check("b2b_ready", tone_ready_out, (n == 575) ? 1 : 0);
      if (n < 512)
        ph = ph + 16'd4096;
    end
    check("b2b_pulses", pulses, 576);
    tick();
    check("b2b_stop", audio_valid_out, 0);

    // tone 7 with a strobe on the accept cycle
    tone_in        = 3'd7;
    tone_valid_in  = 1'b1;
    audio_valid_in = 1'b1;
    tick();
    tone_valid_in  = 1'b0;
    audio_valid_in = 1'b0;
    check("acc_sample", audio_out,       0);
    check("acc_valid",  audio_valid_out, 1);
    check("acc_busy",   busy_out,        1);
    tick();
    for (int n = 0; n < 512; n++) begin
      strobe();
      check("t7_sample", audio_out, t7_pat[n % 8]);
      tick();
    end
    for (int n = 0; n < 64; n++) begin
      check("t7_gap_ready", tone_ready_out, 0);
      strobe();
      check("t7_gap_zero", audio_out, 0);
      tick();
    end
    check("t7_end_ready", tone_ready_out, 1);

    // reset in the middle of a tone 1 burst
    tone_in       = 3'd1;
    tone_valid_in = 1'b1;
    tick();
    tone_valid_in = 1'b0;
    for (int n = 0; n < 10; n++) begin
      strobe();
      tick();
    end
    check("mid_sample", audio_out, 32137);
    check("mid_busy",   busy_out,  1);
    rst_in = 1'b1;
    #1;
    check("mr_audio",  audio_out,       0);
    check("mr_avalid", audio_valid_out, 0);
    check("mr_busy",   busy_out,        0);
    check("mr_ready",  tone_ready_out,  1);
    audio_valid_in = 1'b1;
    tick();
    tick();
    check("mr_hold_valid", audio_valid_out, 0);
    audio_valid_in = 1'b0;
    rst_in = 1'b0;
    tick();
    for (int n = 0; n < 4; n++) begin
      strobe();
      check("post_valid", audio_valid_out, 1);
      check("post_audio", audio_out,       0);
      check("post_busy",  busy_out,        0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_generation_fsm.md
# tone_generation_fsm

Transmit-side counterpart of the tone detector. It accepts 3-bit tone identifiers over a valid/ready handshake and synthesises each one as a fixed-length sine burst followed by a silent guard gap. The output is a 16-bit signed audio sample stream, advanced only on the sample-rate strobe. It sits between the symbol source and the audio output path, and its bursts are what the tone detector's FFT path later classifies.

## Interface
- SAMPLES_PER_SYMBOL, 512: samples per tone burst; must be at least 1.
- GAP_SAMPLES, 64: zero samples after each burst; must be at least 1.
- BASE_INC, 1024: phase increment for tone 0. Tone k uses (k+1)*BASE_INC.
- clk_in  input  1  system clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- tone_in  input  3  tone identifier 0..7.
- tone_valid_in  input  1  tone_in holds a tone to send.
- tone_ready_out  output  1  block can accept a tone; high only in IDLE.
- audio_valid_in  input  1  one-cycle sample-rate strobe.
- audio_out  output  16  signed sample, two's complement.
- audio_valid_out  output  1  audio_out has been updated this cycle.
- busy_out  output  1  high in TONE or GAP.

## Operation
- The phase accumulator is 16 bits wide and wraps modulo 2^16.
- Sine table:
  - 64 entries; entry n = round(32767*sin(2*pi*n/64)).
  - Indexed by phase[15:10].
  - It may be stored as a quarter-wave table, provided the outputs are identical.
- The phase increment is latched at accept time as (tone+1)*BASE_INC, truncated to 16 bits.
- State machine: IDLE, TONE, GAP.
- IDLE:
  - tone_ready_out=1.
  - On a clock where tone_valid_in && tone_ready_out (the accept): latch the increment, clear phase to 0, clear the sample counter, go to TONE.
  - Each audio_valid_in strobe emits audio_out=0.
- TONE:
  - Each strobe emits LUT[phase[15:10]], then phase += inc and counter += 1.
  - On the strobe that emits sample SAMPLES_PER_SYMBOL, clear the counter and go to GAP.
- GAP:
  - Each strobe emits 0 and increments the counter.
  - On the strobe that emits zero number GAP_SAMPLES, go to IDLE.
- Clocks without a strobe change neither phase, counter nor state, except the accept transition out of IDLE.
- tone_valid_in while not in IDLE: ignored. Nothing is latched; the source must hold the tone until it is accepted.
- audio_valid_out is asserted for every strobe in every state, so the output stream never stalls.

## Timing
- Reset values:
  - State IDLE, phase 0, counter 0, increment 0.
  - audio_out=0, audio_valid_out=0, busy_out=0.
  - tone_ready_out=1 once reset is released.
- Strobe to output:
  - audio_out and audio_valid_out are registered and change one cycle after audio_valid_in.
  - audio_valid_out is a one-cycle pulse.
  - audio_out holds its value between strobes.
- Accept:
  - On the accept edge, tone_ready_out falls and busy_out rises.
  - A strobe on the accept cycle is handled as IDLE and outputs 0.
  - The first tone sample is produced by the next strobe after the accept.
- First tone sample is always LUT[0]=0. The sample count includes it.
- Burst length is exactly SAMPLES_PER_SYMBOL strobes; the gap is exactly GAP_SAMPLES strobes.
- tone_ready_out rises on the edge that processes the final gap strobe. The next accept is possible on the following cycle.
- Back-to-back strobes (one per clock) are supported with no lost samples.
- Reset asserted mid-burst:
  - Immediate return to reset values. The in-flight tone is discarded.
  - audio_valid_out stays low while rst_in is high.

## Test plan
- Reset check: pulse rst_in mid-burst -> audio_out=0, audio_valid_out=0, busy_out=0, tone_ready_out=1, with no further tone samples.
- Tone 0, strobe every 7 cycles:
  - Samples 0..3 = 0, 3212, 6393, 9512.
  - Exactly 512 tone samples, then 64 zeros, then tone_ready_out=1.
- Tone 7 (inc 8192): samples cycle 0, 23170, 32767, 23170, 0, -23170, -32767, -23170, repeating with period 8.
- Accept while busy: assert tone_valid_in with tone 3 during TONE -> tone_ready_out stays 0, nothing is accepted, and the tone 3 burst starts only after the gap ends.
- Strobe on the accept cycle -> that sample is 0, and the following strobe emits LUT[0]=0 as tone sample 0 (counter reaches 512 at the correct strobe).
- Back-to-back strobes on every clock for a full burst plus gap -> 576 valid pulses with no missing or duplicated samples.
